// File: rtl/text_ram_pkg.sv
// Shared definitions for the text/glyph RAM port-B arbiter.
// Holds the default RAM geometry and the fill engine state encoding.
package text_ram_pkg;

    localparam int TEXT_RAM_ADDR_W = 15;
    localparam int TEXT_RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/text_ram_fill_fsm.sv
// Hardware fill engine: latches base/length/value on a start pulse, requests
// one RAM write per cycle while filling, advances on each grant and pulses
// o_done one cycle after passing through DONE.
module text_ram_fill_fsm
    import text_ram_pkg::*;
#(
    parameter int ADDR_W = TEXT_RAM_ADDR_W,
    parameter int DATA_W = TEXT_RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_len,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_grant,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_value,
    output logic              o_busy,
    output logic              o_done
);

    fill_state_e       r_state;
    fill_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rem;
    logic [DATA_W-1:0] r_value;
    logic              r_done;
    logic              w_latch;
    logic              w_step;

    // State register; reset abandons any fill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, write request and busy flag.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_step      = 1'b0;
        o_req       = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_latch     = 1'b1;
                    w_state_nxt = (i_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                o_req  = 1'b1;
                o_busy = 1'b1;
                if (i_grant) begin
                    w_step = 1'b1;
                    if (r_rem == ADDR_W'(1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Remaining-word counter and completion pulse (control, cleared on reset).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_latch) begin
                r_rem <= i_len;
            end else if (w_step) begin
                r_rem <= r_rem - ADDR_W'(1);
            end
        end
    end

    // Fill address and value; address wraps naturally at the top of the RAM.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_addr  <= i_base;
            r_value <= i_value;
        end else if (w_step) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr  = r_addr;
    assign o_value = r_value;
    assign o_done  = r_done;

endmodule

// File: rtl/text_ram_port_arbiter.sv
// Port-B owner for the shared text/glyph RAM. Arbitrates between the core
// load/store path and the fill engine, registers the granted access onto
// ram_*, and returns core read data two cycles after acceptance.
// Build option: define ARB_ROUND_ROBIN_EN to alternate contested grants;
// otherwise the core has fixed priority over the fill engine.
module text_ram_port_arbiter
    import text_ram_pkg::*;
#(
    parameter int ADDR_W = TEXT_RAM_ADDR_W,
    parameter int DATA_W = TEXT_RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ready,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W-1:0] clr_len,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              w_fill_req;
    logic              w_fill_gnt;
    logic              w_core_gnt;
    logic [ADDR_W-1:0] w_fill_addr;
    logic [DATA_W-1:0] w_fill_value;
    logic              r_tag_p1;
    logic              r_tag_p2;

    text_ram_fill_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk     (clk),
        .rst     (rst),
        .i_start (clr_start),
        .i_base  (clr_base),
        .i_len   (clr_len),
        .i_value (clr_value),
        .i_grant (w_fill_gnt),
        .o_req   (w_fill_req),
        .o_addr  (w_fill_addr),
        .o_value (w_fill_value),
        .o_busy  (clr_busy),
        .o_done  (clr_done)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_fill;
    logic w_contested;

    // Contested cycles go to whoever the pointer names; otherwise the lone requester wins.
    always_comb begin
        w_contested = core_req & w_fill_req;
        if (w_contested) begin
            w_core_gnt = ~r_rr_fill;
            w_fill_gnt = r_rr_fill;
        end else begin
            w_core_gnt = core_req;
            w_fill_gnt = w_fill_req;
        end
    end

    // Round-robin pointer flips after each contested grant; starts on the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_fill <= 1'b0;
        end else if (w_contested) begin
            r_rr_fill <= ~r_rr_fill;
        end
    end
`else
    // Fixed priority: the fill engine only gets cycles the core leaves idle.
    always_comb begin
        w_core_gnt = core_req;
        w_fill_gnt = w_fill_req & ~core_req;
    end
`endif

    assign core_ready = w_core_gnt;

    // Port-B request stage: load on grant, otherwise drop write enable and hold the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (w_core_gnt) begin
            ram_we    <= core_we;
            ram_addr  <= core_addr;
            ram_wdata <= core_wdata;
        end else if (w_fill_gnt) begin
            ram_we    <= 1'b1;
            ram_addr  <= w_fill_addr;
            ram_wdata <= w_fill_value;
        end else begin
            ram_we <= 1'b0;
        end
    end

    // Read tag shift register: marks which RAM return cycles belong to core reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_p1 <= 1'b0;
            r_tag_p2 <= 1'b0;
        end else begin
            r_tag_p1 <= w_core_gnt & ~core_we;
            r_tag_p2 <= r_tag_p1;
        end
    end

    assign core_rvalid = r_tag_p2;
    assign core_rdata  = r_tag_p2 ? ram_rdata : '0;

endmodule

// File: doc/text_ram_port_arbiter.md
# text_ram_port_arbiter

Owns port B of the shared text/glyph RAM and shares it between the core's load/store path and a built-in hardware fill engine used to clear or paint screen regions. Port A stays dedicated to the VGA dispatch path and is not touched. The block sequences every port-B access through a registered request stage, runs the fill state machine, and returns tagged read data to the core with fixed latency.

## Interface
- ADDR_W, 15, RAM word-address width (32K x 16 RAM)
- DATA_W, 16, RAM data width
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core access request, held until accepted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  word address
- core_wdata  in  DATA_W  write data
- core_ready  out  1  request accepted this cycle when core_req & core_ready
- core_rvalid  out  1  one-cycle pulse, core_rdata valid
- core_rdata  out  DATA_W  read data
- clr_start  in  1  one-cycle pulse, begin fill
- clr_base  in  ADDR_W  first fill address, sampled on clr_start
- clr_len  in  ADDR_W  word count, sampled on clr_start
- clr_value  in  DATA_W  fill word, sampled on clr_start
- clr_busy  out  1  fill in progress
- clr_done  out  1  one-cycle pulse at fill completion
- ram_we  out  1  registered write enable to RAM port B
- ram_addr  out  ADDR_W  registered address to port B
- ram_wdata  out  DATA_W  registered write data to port B
- ram_rdata  in  DATA_W  port B read data (synchronous RAM, 1-cycle read)

## Operation
- Each cycle at most one requester granted; grant loads ram_we/ram_addr/ram_wdata registers. No grant: ram_we <= 0, ram_addr/ram_wdata hold.
- core_ready is combinational: 1 when core_req and arbitration selects core this cycle (see Configuration). Core must hold request fields stable until accepted.
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: clr_start latches base/len/value; len = 0 -> DONE; else -> FILL. clr_start outside IDLE ignored.
  - FILL: requests a write each cycle; on grant writes value at current address, address += 1 modulo 2^ADDR_W (wraps 0x7FFF -> 0x0000), remaining -= 1; last grant -> DONE.
  - DONE: clr_done = 1 for one cycle, -> IDLE.
- clr_busy = 1 in FILL and DONE.
- Read tag pipeline: 2-stage shift register marks core reads; fill writes never produce rvalid.
- Simultaneous core write and fill write to same address in one cycle impossible (single grant); ordering is grant order.

## Timing
- Reset values: core_rvalid 0, core_rdata 0, clr_busy 0, clr_done 0, ram_we 0, ram_addr 0, ram_wdata 0, FSM IDLE, tag pipeline cleared, round-robin pointer = core.
- Core read accepted in cycle T: ram_addr driven in T+1, core_rvalid and core_rdata (= ram_rdata) in T+2. Back-to-back reads sustain one per cycle.
- Write accepted in T: ram_we high in T+1 only.
- Fill of N words with no core traffic: clr_start in T, writes on ram_* during T+2..T+N+1, clr_done in T+N+2 (FILL entered T+1, grant each cycle).
- Reset asserted mid-fill: FSM -> IDLE immediately, no clr_done, pending read tags dropped (no rvalid).

## Configuration
- ARB_ROUND_ROBIN_EN defined: when core and fill both request, grants alternate; pointer flips after every contested grant; uncontested requester always granted.
- Undefined: fixed priority, core always wins; fill only uses cycles with core_req = 0 (may starve under continuous core traffic).

## Structure
- Package text_ram_pkg: ADDR_W/DATA_W defaults, fill state enum (IDLE, FILL, DONE).
- Sub-module text_ram_fill_fsm: fill state machine, address/count registers, request/grant interface; arbiter, output registers and read tag pipeline stay in top.

## Test plan
- Reset mid-fill (base 0x0100, len 8, rst after 3 writes) -> outputs at reset values, no clr_done, next clr_start works normally.
- Core read 0x0042 in idle RAM holding 0xBEEF -> core_ready same cycle, core_rvalid/core_rdata = 0xBEEF exactly 2 cycles later.
- Fill base 0x7FFE, len 4, value 0x0720 -> writes to 0x7FFE, 0x7FFF, 0x0000, 0x0001; clr_done 6 cycles after clr_start.
- Fill len 0 -> no ram_we, clr_busy high 1 cycle, clr_done 2 cycles after clr_start.
- Continuous core reads during 4-word fill: with ARB_ROUND_ROBIN_EN, grants alternate core/fill, fill completes in 8 grant cycles; without, zero fill writes until core_req drops.
- clr_start pulsed again during FILL -> ignored, original len/value written unchanged.
